data_mem_responder: RTL and testbench

Responder side of the Memory-stage data-memory interface: accepts one load or store request at a time over a valid/ready handshake, models a configurable number of wait states, performs byte/half/word stores with byte enables and sign/zero-extending loads, and returns the result over a response handshake. It sits behind the Memory stage as the multi-cycle data memory the pipeline stalls on, replacing the single-cycle array for latency-tolerant operation.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_load_extend.sv | 30 +++
 rtl/data_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: request type codes, FSM states,
// and the word geometry.
package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_SB  = 2'b00,
    ST_SH  = 2'b01,
    ST_SW  = 2'b10,
    ST_ILL = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_ACCESS = 2'b10,
    S_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_load_extend.sv
// Lane select and sign/zero extension of a loaded word; purely combinational,
// no flow control. Illegal load codes yield zero.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  load_type_e  i_load_type,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_lane +: 8];
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = '0;
    case (i_load_type)
      LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LD_LH:   o_data = {{16{w_half[15]}}, w_half};
      LD_LW:   o_data = i_word;
      LD_LBU:  o_data = {24'd0, w_byte};
      LD_LHU:  o_data = {16'd0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory: one request at a time, response WAIT_STATES+2 cycles after the request cycle.
// req_ready only in IDLE; a response is held in RESP until rsp_ready.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_store_type,
  input  logic [2:0]  req_load_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_write;
  store_type_e r_store_type;
  load_type_e  r_load_type;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_err;
  logic        w_oor;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic [AW-1:0] w_idx;

  assign w_accept = req_valid && req_ready;
  assign w_idx    = r_addr[AW+1:2];
  assign w_oor    = ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_word   = r_mem[w_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (r_cnt == 4'd1) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // req_ready is also masked by reset so the requester never sees IDLE while held in reset.
  always_comb begin
    req_ready = rst && (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

  always_comb begin
    w_err = 1'b0;
    if (r_write) begin
      case (r_store_type)
        ST_SB:   w_err = 1'b0;
        ST_SH:   w_err = r_addr[0];
        ST_SW:   w_err = |r_addr[1:0];
        default: w_err = 1'b1;
      endcase
    end else begin
      case (r_load_type)
        LD_LB, LD_LBU: w_err = 1'b0;
        LD_LH, LD_LHU: w_err = r_addr[0];
        LD_LW:         w_err = |r_addr[1:0];
        default:       w_err = 1'b1;
      endcase
    end
    if (w_oor) w_err = 1'b1;
  end

  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = r_wdata;
    case (r_store_type)
      ST_SB: begin
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      ST_SH: begin
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      ST_SW:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_we = (r_state == S_ACCESS) && r_write && !w_err;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

  mem_load_extend u_load_extend (
    .i_word      (w_word),
    .i_lane      (r_addr[1:0]),
    .i_load_type (r_load_type),
    .o_data      (w_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_store_type <= ST_SB;
      r_load_type  <= LD_LB;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_error  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt        <= 4'(WAIT_STATES);
        r_write      <= req_write;
        r_store_type <= store_type_e'(req_store_type);
        r_load_type  <= load_type_e'(req_load_type);
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_error <= w_err;
        r_rsp_rdata <= (!r_write && !w_err) ? w_ext : 32'd0;
      end else if (rsp_valid && rsp_ready) begin
        r_rsp_error <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (0 and 2 wait states) share request fields;
// a negedge monitor checks data, error flag and first-valid latency.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_store_type = 2'b00;
  logic [2:0]  req_load_type = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_error;
  logic [1:0]  busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] prev_v = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_store_type(req_store_type), .req_load_type(req_load_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]), .busy(busy[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_store_type(req_store_type), .req_load_type(req_load_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: latency on the first valid cycle, data/error on the handshake cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prev_v <= 2'b00;
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        int   have;
        have = (d == 0) ? q0.size() : q1.size();
        if (rsp_valid[d]) begin
          if (have == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp dut%0d: got rdata 0x%08h with no pending request", d, rsp_rdata[d]);
          end else begin
            e = (d == 0) ? q0[0] : q1[0];
            if (!prev_v[d]) chk($sformatf("latency_dut%0d", d), 32'(cyc), 32'(e.cyc + ((d == 0) ? 0 : 2) + 2));
            if (rsp_ready) begin
              chk($sformatf("rdata_dut%0d", d), rsp_rdata[d], e.rdata);
              chk($sformatf("error_dut%0d", d), {31'd0, rsp_error[d]}, {31'd0, e.err});
              if (d == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
      prev_v <= rsp_valid;
    end
  end

  task automatic wait_ready(input int d);
    int n = 0;
    while (!req_ready[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[d]) fail_now($sformatf("req_ready_timeout_dut%0d", d));
  endtask

  task automatic issue(input int d, input logic w, input logic [1:0] st, input logic [2:0] ld,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    wait_ready(d);
    req_write = w; req_store_type = st; req_load_type = ld;
    req_addr = a; req_wdata = wd;
    req_valid[d] = 1'b1;
    e.rdata = er; e.err = ee; e.cyc = cyc;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    int n;
    #2 rst = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready[1]}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    chk("rst_rdata", rsp_rdata[1], 32'd0);
    chk("rst_error", {31'd0, rsp_error[1]}, 32'd0);
    chk("rst_busy", {30'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("idle_req_ready", {30'd0, req_ready}, 32'd3);

    // SW then LW, byte/half merges and extensions on the 2-wait-state responder.
    issue(1, 1, 2'b10, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    issue(1, 0, 2'b10, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    issue(1, 1, 2'b10, 3'b010, 32'h10, 32'h11223344, 32'h0, 0);
    issue(1, 1, 2'b00, 3'b010, 32'h13, 32'h00000080, 32'h0, 0);
    issue(1, 0, 2'b10, 3'b010, 32'h10, 32'h0, 32'h80223344, 0);
    issue(1, 0, 2'b10, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    issue(1, 0, 2'b10, 3'b100, 32'h13, 32'h0, 32'h00000080, 0);
    issue(1, 1, 2'b01, 3'b010, 32'h11, 32'h0000BEEF, 32'h0, 1);
    issue(1, 0, 2'b10, 3'b010, 32'h10, 32'h0, 32'h80223344, 0);
    issue(1, 0, 2'b10, 3'b001, 32'h12, 32'h0, 32'hFFFF8022, 0);
    issue(1, 0, 2'b10, 3'b101, 32'h12, 32'h0, 32'h00008022, 0);
    issue(1, 0, 2'b10, 3'b000, 32'h12, 32'h0, 32'h00000022, 0);
    issue(1, 0, 2'b10, 3'b001, 32'h10, 32'h0, 32'h00003344, 0);
    issue(1, 1, 2'b01, 3'b010, 32'h12, 32'h0000ABCD, 32'h0, 0);
    issue(1, 0, 2'b10, 3'b010, 32'h10, 32'h0, 32'hABCD3344, 0);
    issue(1, 1, 2'b11, 3'b010, 32'h10, 32'h99999999, 32'h0, 1);
    issue(1, 0, 2'b10, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    issue(1, 0, 2'b10, 3'b010, 32'h10, 32'h0, 32'hABCD3344, 0);
    issue(1, 0, 2'b10, 3'b010, 32'h1002, 32'h0, 32'h0, 1);
    issue(1, 1, 2'b10, 3'b010, 32'h1000, 32'h5A5A5A5A, 32'h0, 1);
    issue(1, 0, 2'b10, 3'b000, 32'h1000, 32'h0, 32'h0, 1);
    issue(1, 1, 2'b10, 3'b010, 32'h40, 32'h01010101, 32'h0, 0);
    drain();

    // Backpressure: response held for 5 cycles while a stray store is offered.
    rsp_ready = 1'b0;
    issue(1, 0, 2'b10, 3'b010, 32'h10, 32'h0, 32'hABCD3344, 0);
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid[1]) fail_now("stall_rsp_timeout");
    req_write = 1'b1; req_store_type = 2'b10; req_addr = 32'h40; req_wdata = 32'h55555555;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", {31'd0, rsp_valid[1]}, 32'd1);
      chk("stall_rdata", rsp_rdata[1], 32'hABCD3344);
      chk("stall_req_ready", {31'd0, req_ready[1]}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_req_ready", {31'd0, req_ready[1]}, 32'd1);
    chk("release_busy", {31'd0, busy[1]}, 32'd0);
    issue(1, 0, 2'b10, 3'b010, 32'h40, 32'h0, 32'h01010101, 0);

    // Reset during WAIT drops the pending store.
    issue(1, 1, 2'b10, 3'b010, 32'h20, 32'h12345678, 32'h0, 0);
    drain();
    wait_ready(1);
    req_write = 1'b1; req_store_type = 2'b10; req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("wait_busy", {31'd0, busy[1]}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("midrst_rdata", rsp_rdata[1], 32'd0);
    chk("midrst_error", {31'd0, rsp_error[1]}, 32'd0);
    chk("midrst_busy", {30'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("postrst_req_ready", {31'd0, req_ready[1]}, 32'd1);
    issue(1, 0, 2'b10, 3'b010, 32'h20, 32'h0, 32'h12345678, 0);
    drain();

    // Zero wait states: half loads of 0x8001xxxx.
    issue(0, 1, 2'b10, 3'b010, 32'h10, 32'h80011234, 32'h0, 0);
    issue(0, 0, 2'b10, 3'b101, 32'h12, 32'h0, 32'h00008001, 0);
    issue(0, 0, 2'b10, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 0);
    issue(0, 0, 2'b10, 3'b100, 32'h11, 32'h0, 32'h00000012, 0);
    issue(0, 0, 2'b10, 3'b010, 32'h100, 32'h0, 32'h0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
